// File: rtl/prog_store_pkg.sv
// Shared types for the instruction store: word/address types, instruction fields,
// the NOP encoding used for padding, and the loader state encoding.
package prog_store_pkg;

    typedef logic [3:0] addr_t;
    typedef logic [7:0] data_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] imm;
    } insn_t;

    localparam data_t NOP_INSN = 8'h80;

    typedef enum logic [2:0] {
        HOLD,
        RUN,
        LOAD,
        FILL,
        ERR
    } loader_state_t;

endpackage

// File: rtl/prog_store_ram.sv
// DEPTH x DATA_W register array: async clear to NOP, one synchronous write port,
// one combinational read port.
module prog_store_ram
    import prog_store_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(NOP_INSN);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_store.sv
// Instruction store with host loader: serves fetches combinationally, holds the core
// in reset while loading, pads with NOP and releases the core after HOLD_CYCLES.
module prog_store
    import prog_store_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              cpu_rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   loaded_len
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam int IC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [IC_W-1:0]   IDLE_LAST = IC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W:0]   LAST_PTR  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_PTR = (ADDR_W+1)'(DEPTH);

    loader_state_t     state, state_nxt;
    logic [HC_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [ADDR_W:0]   wr_ptr, wr_ptr_nxt;
    logic [IC_W-1:0]   idle_cnt, idle_cnt_nxt;
    logic              err_nxt;
    logic [ADDR_W:0]   loaded_len_nxt;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              xfer;

    assign ld_ready   = (state == LOAD);
    assign busy       = (state != RUN);
    assign xfer       = ld_valid && ld_ready;
    assign fetch_data = (state == RUN || state == HOLD) ? rd_data : DATA_W'(NOP_INSN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            wr_ptr     <= '0;
            idle_cnt   <= '0;
            err        <= 1'b0;
            loaded_len <= '0;
            cpu_rst_n  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            wr_ptr     <= wr_ptr_nxt;
            idle_cnt   <= idle_cnt_nxt;
            err        <= err_nxt;
            loaded_len <= loaded_len_nxt;
            cpu_rst_n  <= (state_nxt == RUN);
        end
    end

    // ld_start wins over everything, so a same-cycle transfer is dropped
    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = '0;
        wr_ptr_nxt     = wr_ptr;
        idle_cnt_nxt   = idle_cnt;
        err_nxt        = err;
        loaded_len_nxt = loaded_len;
        ram_we         = 1'b0;
        ram_wdata      = ld_data;
        if (ld_start) begin
            state_nxt    = LOAD;
            wr_ptr_nxt   = '0;
            idle_cnt_nxt = '0;
            err_nxt      = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        ram_we       = 1'b1;
                        wr_ptr_nxt   = wr_ptr + 1'b1;
                        idle_cnt_nxt = '0;
                        if (ld_last || wr_ptr == LAST_PTR) begin
                            loaded_len_nxt = wr_ptr + 1'b1;
                            state_nxt      = (wr_ptr + 1'b1 < DEPTH_PTR) ? FILL : HOLD;
                        end
                    end else if (TIMEOUT != 0 && idle_cnt == IDLE_LAST) begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end
                FILL: begin
                    ram_we     = 1'b1;
                    ram_wdata  = DATA_W'(NOP_INSN);
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        state_nxt = HOLD;
                    end
                end
                RUN, ERR: begin
                end
                default: state_nxt = HOLD;
            endcase
        end
    end

    prog_store_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (ram_wdata),
        .raddr (fetch_addr),
        .rdata (rd_data)
    );

endmodule

// File: doc/prog_store.md
Name: prog_store

Overview:
- Instruction store and program loader that sits directly upstream of the 4-bit CPU core.
- Serves instruction bytes combinationally on the fetch address the core drives, so the core samples data in the same cycle it presents the address.
- Host loader interface: a byte-wide valid/ready stream.
- During a load it holds the core in reset. Afterwards it pads unused words with NOP and releases the core after a fixed hold period.

Parameters:
- DEPTH, 16, number of instruction words (power of two).
- ADDR_W, 4, fetch/write address width, equal to log2(DEPTH).
- DATA_W, 8, instruction width (opcode[7:4], imm[3:0]).
- HOLD_CYCLES, 2, cycles the core reset stays low after a load or reset completes (at least 1).
- TIMEOUT, 255, idle cycles allowed between load bytes before the load is aborted; 0 disables the timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fetch_addr  in  ADDR_W  instruction address from the core.
- fetch_data  out  DATA_W  instruction word to the core.
- cpu_rst_n  out  1  registered active-low reset to the core.
- ld_start  in  1  one-cycle pulse that begins a load.
- ld_valid  in  1  host byte valid.
- ld_ready  out  1  loader accepts a byte.
- ld_data  in  DATA_W  host byte.
- ld_last  in  1  marks the final byte; qualified by a transfer.
- busy  out  1  high whenever state is not RUN.
- err  out  1  sticky flag: the last load timed out.
- loaded_len  out  ADDR_W+1  byte count of the last successful load.

Behaviour:
- States: HOLD, RUN, LOAD, FILL, ERR.
- Reset values:
  - state=HOLD, hold_cnt=0, wr_ptr=0, idle_cnt=0.
  - All memory words = NOP_INSN (8'h80).
  - cpu_rst_n=0, ld_ready=0, busy=1, err=0, loaded_len=0.
- fetch_data:
  - Equals mem[fetch_addr] combinationally in RUN and HOLD.
  - Forced to NOP_INSN in LOAD, FILL and ERR.
- Transfer condition: ld_valid && ld_ready.
- ld_ready: 1 only in LOAD. It is combinational from state and does not depend on ld_valid.
- HOLD:
  - hold_cnt increments each cycle.
  - When hold_cnt == HOLD_CYCLES-1, go to RUN and clear hold_cnt.
  - cpu_rst_n=1 in the first RUN cycle.
- RUN: cpu_rst_n=1. ld_start -> LOAD.
- ld_start in RUN, HOLD, ERR or LOAD (restart) has the same effect:
  - Next state is LOAD, wr_ptr=0, idle_cnt=0, err cleared.
  - cpu_rst_n goes low on the following clock edge.
- LOAD, on a transfer:
  - mem[wr_ptr] <= ld_data, wr_ptr++, idle_cnt=0.
  - ld_last, or wr_ptr==DEPTH-1: loaded_len <= wr_ptr+1 and the load terminates.
  - If wr_ptr+1 < DEPTH, go to FILL. Otherwise skip FILL and go straight to HOLD.
  - The DEPTH-th byte auto-terminates the load even when ld_last=0.
- LOAD, on a cycle without a transfer:
  - idle_cnt increments.
  - TIMEOUT!=0 and idle_cnt == TIMEOUT-1: go to ERR, err=1, loaded_len unchanged.
  - Already-written words are not restored after a timeout.
- FILL:
  - Each cycle writes mem[wr_ptr] <= NOP_INSN and increments wr_ptr.
  - Go to HOLD after writing DEPTH-1.
  - Ignores ld_valid. ld_start restarts the load.
- ERR: cpu_rst_n=0 and busy=1 until ld_start.
- Priority: ld_start outranks every other event in the same cycle, including a transfer, which is then dropped.
- Widths:
  - wr_ptr is ADDR_W+1 bits so it cannot alias at DEPTH.
  - idle_cnt is sized to hold TIMEOUT.
  - No arithmetic on data.
- An asynchronous reset mid-load immediately aborts the load and reinitialises all memory to NOP.

Decomposition:
- Shared types package holds:
  - addr_t/data_t, with the opcode/imm instruction fields.
  - NOP_INSN = 8'h80.
  - A new enum loader_state_t {HOLD, RUN, LOAD, FILL, ERR}.
- One natural sub-module, prog_store_ram: DEPTH x DATA_W register array with asynchronous clear to NOP_INSN, one synchronous write port and one combinational read port.
- The FSM, counters and fetch mux live in prog_store.

Test Plan:
- Reset release:
  - cpu_rst_n stays 0 for 2 cycles after reset deasserts, then goes 1.
  - fetch_addr=4'h3 -> fetch_data=8'h80.
- Load 3 bytes 8'h31, 8'h52, 8'hF0 with ld_last on the third:
  - FILL runs 13 cycles, then HOLD runs 2 cycles.
  - loaded_len=3.
  - In RUN, fetch addr 0/1/2/3 -> 31/52/F0/80.
- Load 16 bytes 8'h00..8'h0F without ld_last:
  - Auto-terminates with no FILL; goes LOAD->HOLD directly.
  - loaded_len=16, addr 15 -> 8'h0F.
- Host backpressure:
  - ld_valid toggles 1,0,0,1 -> exactly 2 writes.
  - ld_ready stays 1 throughout LOAD.
  - With TIMEOUT=4, a 4-cycle ld_valid gap -> ERR: err=1, cpu_rst_n=0, fetch_data=80.
  - A subsequent ld_start clears err.
- ld_start coincident with a transfer at wr_ptr=5:
  - The byte is dropped and wr_ptr=0.
  - The next byte lands at address 0.
- Asynchronous reset asserted during FILL:
  - All words read 8'h80, loaded_len=0, state returns to HOLD.
